// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, select fields
// and the one-hot instruction class produced by the decoder.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6
  } state_e;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_BGEZAL = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MDR = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_RS  = 2'b11;

  localparam int CLS_ADDU   = 0;
  localparam int CLS_SUBU   = 1;
  localparam int CLS_JR     = 2;
  localparam int CLS_ORI    = 3;
  localparam int CLS_LW     = 4;
  localparam int CLS_SW     = 5;
  localparam int CLS_BEQ    = 6;
  localparam int CLS_LUI    = 7;
  localparam int CLS_J      = 8;
  localparam int CLS_JAL    = 9;
  localparam int CLS_BGEZAL = 10;
  localparam int CLS_ILL    = 11;
  localparam int NUM_CLS    = 12;

  typedef logic [NUM_CLS-1:0] cls_t;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] alu_op;
    logic       alub_sel;
    logic [1:0] ext_op;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [1:0] npc_sel;
    logic       illegal;
  } ctrl_out_t;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and status in, strobes and selects out.
interface multi_cycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       gez;
  logic       mem_ready;

  logic       pc_wr;
  logic       ir_wr;
  logic       reg_wr;
  logic       mem_rd;
  logic       mem_wr;
  logic [1:0] alu_op;
  logic       alub_sel;
  logic [1:0] ext_op;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic [1:0] npc_sel;
  logic [2:0] state;
  logic       illegal;

  modport master (
    input  op, funct, zero, gez, mem_ready,
    output pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, alu_op, alub_sel,
           ext_op, reg_dst, wd_sel, npc_sel, state, illegal
  );

  modport slave (
    output op, funct, zero, gez, mem_ready,
    input  pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, alu_op, alub_sel,
           ext_op, reg_dst, wd_sel, npc_sel, state, illegal
  );
endinterface

// File: rtl/instr_decode.sv
// Combinational op/funct decode into a one-hot instruction class; anything
// unrecognised lands in the illegal bit.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls[CLS_ADDU] = 1'b1;
          FN_SUBU: cls[CLS_SUBU] = 1'b1;
          FN_JR:   cls[CLS_JR]   = 1'b1;
          default: cls[CLS_ILL]  = 1'b1;
        endcase
      end
      OP_ORI:    cls[CLS_ORI]    = 1'b1;
      OP_LW:     cls[CLS_LW]     = 1'b1;
      OP_SW:     cls[CLS_SW]     = 1'b1;
      OP_BEQ:    cls[CLS_BEQ]    = 1'b1;
      OP_LUI:    cls[CLS_LUI]    = 1'b1;
      OP_J:      cls[CLS_J]      = 1'b1;
      OP_JAL:    cls[CLS_JAL]    = 1'b1;
      OP_BGEZAL: cls[CLS_BGEZAL] = 1'b1;
      default:   cls[CLS_ILL]    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM. Outputs are a function of the current
// state and the IR decode, and are forced to zero while reset_n is low.
module multi_cycle_ctrl
  import ctrl_pkg::*;
(
  input logic               clk,
  input logic               reset_n,
  multi_cycle_ctrl_if.master bus
);

  state_e    state_d, state_q;
  cls_t      dec_cls;
  ctrl_out_t out_d, out_g;
  logic      is_rtype, is_exe, is_branch;

  instr_decode u_decode (
    .op    (bus.op),
    .funct (bus.funct),
    .cls   (dec_cls)
  );

  // IR holds op/funct for the whole instruction, so the live decode stays valid past DECODE.
  assign is_rtype  = dec_cls[CLS_ADDU] | dec_cls[CLS_SUBU];
  assign is_exe    = is_rtype | dec_cls[CLS_ORI] | dec_cls[CLS_LUI]
                   | dec_cls[CLS_LW] | dec_cls[CLS_SW];
  assign is_branch = dec_cls[CLS_BEQ] | dec_cls[CLS_BGEZAL];

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    out_d   = '0;
    case (state_q)
      S_FETCH: begin
        out_d.ir_wr   = 1'b1;
        out_d.pc_wr   = 1'b1;
        out_d.npc_sel = NPC_PC4;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        if (dec_cls[CLS_J] || dec_cls[CLS_JAL]) begin
          out_d.pc_wr   = 1'b1;
          out_d.npc_sel = NPC_J;
        end
        if (dec_cls[CLS_JAL]) begin
          out_d.reg_wr  = 1'b1;
          out_d.reg_dst = DST_RA;
          out_d.wd_sel  = WD_PC;
        end
        if (dec_cls[CLS_JR]) begin
          out_d.pc_wr   = 1'b1;
          out_d.npc_sel = NPC_RS;
        end
        if (is_branch) state_d = S_BRANCH;
        if (is_exe)    state_d = S_EXE;
        out_d.illegal = dec_cls[CLS_ILL];
      end
      S_EXE: begin
        if (dec_cls[CLS_SUBU]) out_d.alu_op = ALU_SUB;
        if (dec_cls[CLS_ORI] || dec_cls[CLS_LUI]) begin
          out_d.alu_op   = ALU_OR;
          out_d.alub_sel = 1'b1;
          out_d.ext_op   = dec_cls[CLS_LUI] ? EXT_LUI : EXT_ZERO;
        end
        if (dec_cls[CLS_LW] || dec_cls[CLS_SW]) begin
          out_d.alu_op   = ALU_ADD;
          out_d.alub_sel = 1'b1;
          out_d.ext_op   = EXT_SIGN;
        end
        if (dec_cls[CLS_LW])      state_d = S_MEM_RD;
        else if (dec_cls[CLS_SW]) state_d = S_MEM_WR;
        else                      state_d = S_WB;
      end
      S_MEM_RD: begin
        out_d.mem_rd = 1'b1;
        if (bus.mem_ready) state_d = S_WB;
      end
      S_MEM_WR: begin
        out_d.mem_wr = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_WB: begin
        out_d.reg_wr  = 1'b1;
        out_d.reg_dst = is_rtype ? DST_RD : DST_RT;
        out_d.wd_sel  = dec_cls[CLS_LW] ? WD_MDR : WD_ALU;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        out_d.npc_sel = NPC_BR;
        if (dec_cls[CLS_BEQ]) begin
          out_d.alu_op = ALU_SUB;
          out_d.pc_wr  = bus.zero;
        end
        if (dec_cls[CLS_BGEZAL]) begin
          // Link is written whether or not the branch is taken.
          out_d.reg_wr  = 1'b1;
          out_d.reg_dst = DST_RA;
          out_d.wd_sel  = WD_PC;
          out_d.pc_wr   = bus.gez;
        end
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign out_g = reset_n ? out_d : '0;

  assign bus.pc_wr    = out_g.pc_wr;
  assign bus.ir_wr    = out_g.ir_wr;
  assign bus.reg_wr   = out_g.reg_wr;
  assign bus.mem_rd   = out_g.mem_rd;
  assign bus.mem_wr   = out_g.mem_wr;
  assign bus.alu_op   = out_g.alu_op;
  assign bus.alub_sel = out_g.alub_sel;
  assign bus.ext_op   = out_g.ext_op;
  assign bus.reg_dst  = out_g.reg_dst;
  assign bus.wd_sel   = out_g.wd_sel;
  assign bus.npc_sel  = out_g.npc_sel;
  assign bus.illegal  = out_g.illegal;
  assign bus.state    = state_q;

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 reset_n  in  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-003 op  in  6  instruction [31:26], from IR.
REQ-004 funct  in  6  instruction [5:0], from IR.
REQ-005 zero  in  1  ALU result == 0; used by beq.
REQ-006 gez  in  1  GPR[rs] >= 0 (signed); used by bgezal.
REQ-007 mem_ready  in  1  data memory has completed the current access.
REQ-008 pc_wr  out  1  PC load enable.
REQ-009 ir_wr  out  1  IR load enable.
REQ-010 reg_wr  out  1  GPR write enable.
REQ-011 mem_rd / mem_wr  out  1 each  data memory read/write strobes.
REQ-012 alu_op  out  2  00 add, 01 sub, 10 or.
REQ-013 alub_sel  out  1  0 GPR[rt], 1 extended immediate.
REQ-014 ext_op  out  2  00 zero-ext, 01 sign-ext, 10 lui (imm<<16).
REQ-015 reg_dst  out  2  00 rt, 01 rd, 10 $31.
REQ-016 wd_sel  out  2  00 ALU result, 01 MDR, 10 PC (already PC+4).
REQ-017 npc_sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 GPR[rs].
REQ-018 state  out  3  current state, for debug.
REQ-019 illegal  out  1  one-cycle pulse on an unrecognised instruction.

Function
REQ-020 Instructions decoded: addu (op 000000, funct 100001), subu (000000/100011), jr (000000/001000), ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011, bgezal 000001.
REQ-021 States: FETCH, DECODE, EXE, MEM_RD, MEM_WR, WB, BRANCH; Moore outputs; every output 0 unless listed.
REQ-022 FETCH: ir_wr=1, pc_wr=1, npc_sel=00; next DECODE.
REQ-023 DECODE, j: pc_wr=1, npc_sel=10; next FETCH.
REQ-024 DECODE, jal: pc_wr=1, npc_sel=10, reg_wr=1, reg_dst=10, wd_sel=10; next FETCH.
REQ-025 DECODE, jr: pc_wr=1, npc_sel=11; next FETCH.
REQ-026 DECODE, beq or bgezal: next BRANCH; addu/subu/ori/lui/lw/sw: next EXE.
REQ-027 DECODE, illegal: illegal=1 for that cycle; next FETCH; no write enables asserted.
REQ-028 EXE drives the ALU controls continuously.
  - addu: alu_op 00, alub_sel 0.
  - subu: alu_op 01, alub_sel 0.
  - ori: alu_op 10, alub_sel 1, ext_op 00.
  - lui: alu_op 10, alub_sel 1, ext_op 10.
  - lw/sw: alu_op 00, alub_sel 1, ext_op 01.
  - Next state: MEM_RD (lw), MEM_WR (sw), else WB.
REQ-029 MEM_RD: mem_rd=1; stays in MEM_RD while mem_ready=0; when mem_ready=1, next WB.
REQ-030 MEM_WR: mem_wr=1; stays in MEM_WR while mem_ready=0; when mem_ready=1, next FETCH.
REQ-031 WB: reg_wr=1; next FETCH.
  - R-type: reg_dst 01, wd_sel 00.
  - ori/lui: reg_dst 00, wd_sel 00.
  - lw: reg_dst 00, wd_sel 01.
REQ-032 BRANCH, beq: alu_op 01, alub_sel 0; pc_wr=zero, npc_sel=01; next FETCH.
REQ-033 BRANCH, bgezal: reg_wr=1, reg_dst=10, wd_sel=10 unconditionally; pc_wr=gez, npc_sel=01; next FETCH.
REQ-034 Cycle counts, no memory wait: j/jal/jr 2; beq/bgezal 3; R-type/ori/lui 4; sw 4; lw 5. Each wait cycle adds 1.
REQ-035 op/funct are held stable by IR (ir_wr=0 outside FETCH); the decode taken in DECODE is used through the end of the instruction.
REQ-036 mem_ready sampled outside MEM_RD/MEM_WR is ignored.

Reset
REQ-037 reset_n=0 at a clock edge forces state=FETCH; all strobes and selects read 0 while reset_n is low.
REQ-038 Reset asserted mid-instruction, including during a memory wait, abandons the instruction; no write enable is asserted in the following cycle.
REQ-039 The first FETCH after reset_n rises performs a normal fetch.

Structure
REQ-040 Shared package ctrl_pkg holds:
  - state encoding;
  - opcode and funct constants;
  - alu_op, ext_op, reg_dst, wd_sel and npc_sel encodings.
REQ-041 One sub-module, instr_decode: combinational op/funct to one-hot instruction class (eleven lines plus illegal). Instantiated once; consumed by the FSM.

Verification
REQ-042 addu (op 000000, funct 100001), mem_ready=1 -> states FETCH,DECODE,EXE,WB,FETCH; reg_wr=1 only in WB with reg_dst=01.
REQ-043 lw with mem_ready low 3 cycles -> mem_rd=1 for 4 cycles; WB with wd_sel=01; 8 cycles total.
REQ-044 beq with zero=0, then with zero=1 -> pc_wr=0 then pc_wr=1 in BRANCH with npc_sel=01.
REQ-045 bgezal with gez=0 -> reg_wr=1, reg_dst=10, pc_wr=0 in BRANCH; repeated with gez=1 -> pc_wr=1.
REQ-046 op 111111 -> illegal pulses one cycle in DECODE; no reg_wr/mem_wr; next state FETCH.
REQ-047 reset_n low during the MEM_WR wait -> next cycle state=FETCH, mem_wr=0.
